and_unit_rr_arbiter: RTL

Round-robin scheduler that shares one registered bitwise-AND unit (result = a & b, one register stage) among NUM_REQ requesters. Each cycle it grants at most one requester and captures that requester's AND result in the output register. It returns the result with the requester ID over a valid/ready response channel. It sits between the client blocks and the shared logic unit and owns all sequencing and back-pressure for that unit.

---
 rtl/and_unit_rr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/and_unit_rr_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND unit among
// NUM_REQ requesters, with a valid/ready response channel and op counter.
module and_unit_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [15:0]              op_count
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [ID_W-1:0]  r_id;
    logic [15:0]      r_cnt;

    logic             w_found;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_can_accept;
    logic             w_xfer;
    logic             w_done;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [ID_W-1:0]  w_ptr_next;
    int               w_sum;

    assign w_can_accept = !r_valid || rsp_ready;
    assign w_xfer       = w_found && w_can_accept && !rst;
    assign w_done       = r_valid && rsp_ready;

    // First set request at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        w_sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_REQ)
                w_sum = w_sum - NUM_REQ;
            w_idx = ID_W'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer)
            req_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_grant == ID_W'(NUM_REQ - 1)) ? '0
                      : w_grant + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_xfer) begin
                r_data  <= w_a & w_b;
                r_id    <= w_grant;
                r_valid <= 1'b1;
                r_ptr   <= w_ptr_next;
            end else if (w_done) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign op_count  = r_cnt;

endmodule
